ir_call_unit: RTL and testbench
===============================

// Module: ir_call_unit
// PURPOSE
//   Registered instruction register with BSR/RET decode and a hardware return-address stack.
//   Captures fetched words from the program ROM on CLK when not held.
//   Flags subroutine call/return and computes the branch target.
//   Pushes/pops return addresses itself so the PC mux needs no separate stack.
//   Sits between the program ROM and the PC/next-address logic.
// PARAMETERS
//   IW        22                        instruction width
//   AW        10                        address/PC width; BSR offset field = PR_code[AW-1:0]
//   DEPTH     8                         return-stack entries (>=2)
//   BSR_OPC   12'b011100000000          value of PR_code[IW-1:AW] that marks BSR (width IW-AW)
//   RET_CODE  22'b0000011000000000000000 full-word RET encoding (width IW)
// PORTS
//   CLK          in   1        rising-edge clock
//   RST_n        in   1        asynchronous reset, active low
//   HOLD         in   1        1 = freeze all state (no capture, no push/pop)
//   flush        in   1        1 = load NOP (all zeros) into IR; priority over HOLD
//   clr_flags    in   1        synchronous clear of sticky overflow/underflow
//   PR_code      in   IW       fetched instruction word
//   pc_in        in   AW       address of PR_code
//   IR_code      out  IW       registered instruction
//   bsr_det      out  1        registered: IR_code is BSR
//   ret_det      out  1        registered: IR_code is RET
//   jump_target  out  AW       BSR target, valid while bsr_det=1
//   ret_addr     out  AW       popped return address, valid while ret_det=1
//   stack_depth  out  $clog2(DEPTH+1)  number of valid stack entries
//   overflow     out  1        sticky: BSR pushed while stack full
//   underflow    out  1        sticky: RET popped while stack empty
// BEHAVIOUR
//   Reset (RST_n=0, async): all outputs 0, stack pointer 0, stack contents 0.
//   Capture cycle = rising CLK with HOLD=0 and flush=0; latency 1 from PR_code to IR_code/dets.
//   Decode, evaluated on PR_code at capture:
//     - RET when PR_code == RET_CODE.
//     - BSR when PR_code[IW-1:AW] == BSR_OPC.
//     - RET takes precedence if both match; otherwise neither.
//   BSR capture:
//     - bsr_det<=1, ret_det<=0.
//     - jump_target <= pc_in + PR_code[AW-1:0], offset two's complement, result mod 2^AW.
//     - push (pc_in+1) mod 2^AW.
//   RET capture:
//     - ret_det<=1, bsr_det<=0.
//     - ret_addr <= top entry; pop.
//   Other capture: both dets 0; jump_target and ret_addr keep their previous values.
//   HOLD=1 (flush=0): every register keeps its value; dets stay asserted if they were.
//     No push/pop occurs, so a held BSR/RET acts on the stack exactly once.
//   flush=1: IR_code<=0, bsr_det<=0, ret_det<=0; stack, pointer and flags unchanged;
//     PR_code is ignored.
//   Stack: circular buffer DEPTH entries, write pointer wraps mod DEPTH.
//     - Push when full: overwrite oldest entry, stack_depth stays DEPTH, overflow<=1.
//     - Pop when empty: ret_addr<=0, stack_depth stays 0, pointer unchanged, underflow<=1.
//     - Otherwise stack_depth +1 on push, -1 on pop.
//   clr_flags=1 on any edge (HOLD ignored): overflow<=0, underflow<=0.
//     A same-cycle new overflow/underflow event wins over the clear.
//   Reset mid-call: stack is emptied; the subsequent RET reports underflow.
// TESTING
//   Reset, then capture PR_code=22'h1C0005 (BSR, +5) at pc_in=10 -> next cycle bsr_det=1,
//     jump_target=15, stack_depth=1.
//   Then capture RET_CODE -> ret_det=1, ret_addr=11, stack_depth=0.
//   BSR offset 10'h3FE at pc_in=1 -> jump_target=10'h3FF (wrap);
//     BSR at pc_in=10'h3FF -> pushes 0.
//   HOLD=1 for 3 cycles after a BSR capture -> bsr_det stays 1, stack_depth stays 1;
//     flush during HOLD -> IR_code=0, dets 0.
//   9 BSRs (pc 0..8), DEPTH=8 -> overflow=1, depth=8;
//     8 RETs return 9,8,...,2; 9th RET -> ret_addr=0, underflow=1.
//   clr_flags pulse -> both flags 0. RST_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ir_call_unit.sv
`default_nettype none
// ============================================================================
// Module      : ir_call_unit
// Description : Registered instruction register with BSR/RET decode and a
//               circular hardware return-address stack. Sits between the
//               program ROM and the PC/next-address logic.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_call_unit #(
    parameter int                  IW       = 22,
    parameter int                  AW       = 10,
    parameter int                  DEPTH    = 8,
    parameter logic [IW-AW-1:0]    BSR_OPC  = 12'b011100000000,
    parameter logic [IW-1:0]       RET_CODE = 22'b0000011000000000000000
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         HOLD,
    input  logic                         flush,
    input  logic                         clr_flags,
    input  logic [IW-1:0]                PR_code,
    input  logic [AW-1:0]                pc_in,
    output logic [IW-1:0]                IR_code,
    output logic                         bsr_det,
    output logic                         ret_det,
    output logic [AW-1:0]                jump_target,
    output logic [AW-1:0]                ret_addr,
    output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int             PW         = $clog2(DEPTH);
    localparam int             DW         = $clog2(DEPTH+1);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [DW-1:0]  DEPTH_FULL = DW'(DEPTH);

    logic [IW-1:0] ir_code_q,     ir_code_d;
    logic          bsr_det_q,     bsr_det_d;
    logic          ret_det_q,     ret_det_d;
    logic [AW-1:0] jump_target_q, jump_target_d;
    logic [AW-1:0] ret_addr_q,    ret_addr_d;
    logic [DW-1:0] depth_q,       depth_d;
    logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
    logic          overflow_q,    overflow_d;
    logic          underflow_q,   underflow_d;
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];

    logic          capture;
    logic          is_ret;
    logic          is_bsr;
    logic          ovf_event;
    logic          unf_event;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    // Decode of the incoming word; RET wins when both encodings match.
    always_comb begin
        capture = !HOLD && !flush;
        is_ret  = (PR_code == RET_CODE);
        is_bsr  = !is_ret && (PR_code[IW-1:AW] == BSR_OPC);
        ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        ptr_dec = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
    end

    // Next-state: IR capture/flush, stack push/pop and sticky flags.
    always_comb begin
        ir_code_d     = ir_code_q;
        bsr_det_d     = bsr_det_q;
        ret_det_d     = ret_det_q;
        jump_target_d = jump_target_q;
        ret_addr_d    = ret_addr_q;
        depth_d       = depth_q;
        wr_ptr_d      = wr_ptr_q;
        mem_d         = mem_q;
        ovf_event     = 1'b0;
        unf_event     = 1'b0;

        if (flush) begin
            // Flush inserts a NOP; the stack is not touched.
            ir_code_d = '0;
            bsr_det_d = 1'b0;
            ret_det_d = 1'b0;
        end else if (capture) begin
            ir_code_d = PR_code;
            bsr_det_d = is_bsr;
            ret_det_d = is_ret;
            if (is_bsr) begin
                // Offset is two's complement, so a plain modular add suffices.
                jump_target_d     = pc_in + PR_code[AW-1:0];
                mem_d[wr_ptr_q]   = pc_in + AW'(1);
                wr_ptr_d          = ptr_inc;
                if (depth_q == DEPTH_FULL) begin
                    // Full: the oldest entry is the one just overwritten.
                    ovf_event = 1'b1;
                end else begin
                    depth_d = depth_q + 1'b1;
                end
            end
            if (is_ret) begin
                if (depth_q == '0) begin
                    ret_addr_d = '0;
                    unf_event  = 1'b1;
                end else begin
                    ret_addr_d = mem_q[ptr_dec];
                    wr_ptr_d   = ptr_dec;
                    depth_d    = depth_q - 1'b1;
                end
            end
        end

        // Clear is honoured even under HOLD; a new event in the same cycle wins.
        overflow_d  = clr_flags ? 1'b0 : overflow_q;
        underflow_d = clr_flags ? 1'b0 : underflow_q;
        if (ovf_event) overflow_d  = 1'b1;
        if (unf_event) underflow_d = 1'b1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ir_code_q     <= '0;
            bsr_det_q     <= 1'b0;
            ret_det_q     <= 1'b0;
            jump_target_q <= '0;
            ret_addr_q    <= '0;
            depth_q       <= '0;
            wr_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            mem_q         <= '{default: '0};
        end else begin
            ir_code_q     <= ir_code_d;
            bsr_det_q     <= bsr_det_d;
            ret_det_q     <= ret_det_d;
            jump_target_q <= jump_target_d;
            ret_addr_q    <= ret_addr_d;
            depth_q       <= depth_d;
            wr_ptr_q      <= wr_ptr_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            mem_q         <= mem_d;
        end
    end

    assign IR_code     = ir_code_q;
    assign bsr_det     = bsr_det_q;
    assign ret_det     = ret_det_q;
    assign jump_target = jump_target_q;
    assign ret_addr    = ret_addr_q;
    assign stack_depth = depth_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_call_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_call_unit
// Description : Self-checking bench for ir_call_unit: directed scenarios with
//               literal expectations plus randomized traffic against a
//               queue-based return-stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_call_unit;

    localparam logic [21:0] RET_W = 22'b0000011000000000000000;
    localparam logic [11:0] BSR_H = 12'b011100000000;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        HOLD = 1'b0;
    logic        flush = 1'b0;
    logic        clr_flags = 1'b0;
    logic [21:0] PR_code = '0;
    logic [9:0]  pc_in = '0;
    logic [21:0] IR_code;
    logic        bsr_det;
    logic        ret_det;
    logic [9:0]  jump_target;
    logic [9:0]  ret_addr;
    logic [3:0]  stack_depth;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [21:0] m_ir  = '0;
    logic        m_bsr = 1'b0;
    logic        m_ret = 1'b0;
    logic [9:0]  m_jt  = '0;
    logic [9:0]  m_ra  = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [9:0]  m_stk [$];

    ir_call_unit dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .HOLD        (HOLD),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .PR_code     (PR_code),
        .pc_in       (pc_in),
        .IR_code     (IR_code),
        .bsr_det     (bsr_det),
        .ret_det     (ret_det),
        .jump_target (jump_target),
        .ret_addr    (ret_addr),
        .stack_depth (stack_depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ir = '0; m_bsr = 1'b0; m_ret = 1'b0; m_jt = '0; m_ra = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        m_stk.delete();
    endtask

    // One clock edge of the architectural behaviour, stack kept as a queue.
    task automatic model_step();
        logic eo, eu;
        eo = 1'b0;
        eu = 1'b0;
        if (flush) begin
            m_ir = '0; m_bsr = 1'b0; m_ret = 1'b0;
        end else if (!HOLD) begin
            m_ir  = PR_code;
            m_ret = (PR_code == RET_W);
            m_bsr = !m_ret && (PR_code[21:10] == BSR_H);
            if (m_bsr) begin
                m_jt = pc_in + PR_code[9:0];
                if (m_stk.size() == 8) begin
                    void'(m_stk.pop_front());
                    eo = 1'b1;
                end
                m_stk.push_back(pc_in + 10'd1);
            end
            if (m_ret) begin
                if (m_stk.size() == 0) begin
                    m_ra = '0;
                    eu = 1'b1;
                end else begin
                    m_ra = m_stk.pop_back();
                end
            end
        end
        if (clr_flags) begin
            m_ovf = 1'b0; m_unf = 1'b0;
        end
        if (eo) m_ovf = 1'b1;
        if (eu) m_unf = 1'b1;
    endtask

    // Drive inputs for one cycle (entered 1 time unit after a rising edge).
    task automatic step(input logic h, input logic f, input logic c,
                        input logic [21:0] pr, input logic [9:0] pc);
        HOLD = h; flush = f; clr_flags = c; PR_code = pr; pc_in = pc;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    function automatic logic [21:0] bsr_w(input logic [9:0] off);
        return {BSR_H, off};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ir"},  32'(IR_code), 32'd0);
        chk({tag, "_bsr"}, 32'(bsr_det), 32'd0);
        chk({tag, "_ret"}, 32'(ret_det), 32'd0);
        chk({tag, "_jt"},  32'(jump_target), 32'd0);
        chk({tag, "_ra"},  32'(ret_addr), 32'd0);
        chk({tag, "_dep"}, 32'(stack_depth), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic async_reset(input string tag);
        #3;
        RST_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero(tag);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_ir",    32'(IR_code),     32'(m_ir));
            chk("m_bsr",   32'(bsr_det),     32'(m_bsr));
            chk("m_ret",   32'(ret_det),     32'(m_ret));
            chk("m_jt",    32'(jump_target), 32'(m_jt));
            chk("m_ra",    32'(ret_addr),    32'(m_ra));
            chk("m_depth", 32'(stack_depth), 32'(m_stk.size()));
            chk("m_ovf",   32'(overflow),    32'(m_ovf));
            chk("m_unf",   32'(underflow),   32'(m_unf));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("rst");
        RST_n = 1'b1;
        chk_en = 1'b1;

        // Basic call and return
        step(0, 0, 0, 22'h1C0005, 10'd10);
        chk("bsr1_det", 32'(bsr_det), 32'd1);
        chk("bsr1_jt",  32'(jump_target), 32'd15);
        chk("bsr1_dep", 32'(stack_depth), 32'd1);
        step(0, 0, 0, RET_W, 10'd16);
        chk("ret1_det", 32'(ret_det), 32'd1);
        chk("ret1_bsr", 32'(bsr_det), 32'd0);
        chk("ret1_ra",  32'(ret_addr), 32'd11);
        chk("ret1_dep", 32'(stack_depth), 32'd0);

        // Address wrap
        step(0, 0, 0, bsr_w(10'h3FE), 10'd1);
        chk("wrap_jt", 32'(jump_target), 32'h3FF);
        step(0, 0, 0, bsr_w(10'h000), 10'h3FF);
        chk("wrap_jt2", 32'(jump_target), 32'h3FF);
        step(0, 0, 0, RET_W, 10'd0);
        chk("wrap_ra0", 32'(ret_addr), 32'd0);
        chk("wrap_unf", 32'(underflow), 32'd0);
        step(0, 0, 0, RET_W, 10'd0);
        chk("wrap_ra2", 32'(ret_addr), 32'd2);

        // HOLD freezes a captured BSR; flush overrides HOLD
        step(0, 0, 0, bsr_w(10'd1), 10'd20);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, RET_W, 10'd0);
            chk("hold_bsr", 32'(bsr_det), 32'd1);
            chk("hold_dep", 32'(stack_depth), 32'd1);
        end
        step(1, 1, 0, RET_W, 10'd0);
        chk("flush_ir",  32'(IR_code), 32'd0);
        chk("flush_bsr", 32'(bsr_det), 32'd0);
        chk("flush_dep", 32'(stack_depth), 32'd1);
        step(0, 0, 0, RET_W, 10'd0);
        chk("hold_ra", 32'(ret_addr), 32'd21);

        // Overflow then full drain and underflow
        for (int i = 0; i < 9; i++) step(0, 0, 0, bsr_w(10'd0), 10'(i));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_dep",  32'(stack_depth), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, RET_W, 10'd0);
            chk("drain_ra", 32'(ret_addr), 32'(9 - i));
        end
        step(0, 0, 0, RET_W, 10'd0);
        chk("unf_ra",   32'(ret_addr), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_dep",  32'(stack_depth), 32'd0);

        // Clear under HOLD
        step(1, 0, 1, 22'd0, 10'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);

        // Reset mid-call empties the stack
        step(0, 0, 0, bsr_w(10'd3), 10'd50);
        async_reset("arst");
        step(0, 0, 0, RET_W, 10'd0);
        chk("arst_ra",  32'(ret_addr), 32'd0);
        chk("arst_unf", 32'(underflow), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int sel;
            logic [21:0] pr;
            sel = $urandom_range(0, 9);
            if (sel < 5)      pr = bsr_w(10'($urandom));
            else if (sel < 8) pr = RET_W;
            else              pr = 22'($urandom);
            if (i == 400) async_reset("rrst");
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, pr, 10'($urandom));
        end

        step(0, 0, 0, 22'd0, 10'd0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
